fwd_operand_stage: RTL

Parametrised successor to the 4-to-1 forwarding operand mux. It sits at the ID/EX boundary of the MIPS pipeline. In ID it pre-decodes the forwarding select for both ALU source operands and detects load-use hazards. It registers the selects and register-file operands into EX, where a 4-way mux per operand picks the register-file value, the EX/MEM result, the MEM/WB result, or zero. It also counts load-use stall cycles for performance monitoring.

---
 rtl/fwd_operand_stage_if.sv | 45 ++++
 rtl/fwd_operand_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/fwd_operand_stage_if.sv
// ID/EX operand-forwarding bus: ID-side decode inputs, live result buses, EX-side outputs.
// The slave modport is the stage itself; the master modport is the pipeline driving it.
interface fwd_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs_addr;
    logic [ADDR_W-1:0] id_rt_addr;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic              idex_wr_en;
    logic [ADDR_W-1:0] idex_rd;
    logic              idex_is_load;
    logic              exmem_wr_en;
    logic [ADDR_W-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic [DATA_W-1:0] memwb_result;
    logic              ex_hold;
    logic              ex_flush;
    logic              hazard_stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_op_a;
    logic [DATA_W-1:0] ex_op_b;
    logic [1:0]        ex_sel_a;
    logic [1:0]        ex_sel_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               idex_wr_en, idex_rd, idex_is_load, exmem_wr_en, exmem_rd,
               exmem_result, memwb_result, ex_hold, ex_flush,
        input  hazard_stall, ex_valid, ex_op_a, ex_op_b, ex_sel_a, ex_sel_b,
               stall_count
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               idex_wr_en, idex_rd, idex_is_load, exmem_wr_en, exmem_rd,
               exmem_result, memwb_result, ex_hold, ex_flush,
        output hazard_stall, ex_valid, ex_op_a, ex_op_b, ex_sel_a, ex_sel_b,
               stall_count
    );
endinterface

// File: rtl/fwd_operand_stage.sv
// Purpose: ID/EX forwarding-select pre-decode, load-use detection and EX operand mux.
// Latency: ID inputs registered in 1 cycle; EX operands follow live result buses combinationally.
// Backpressure: ex_hold freezes EX registers; load-use inserts a bubble and raises hazard_stall upstream.
module fwd_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    fwd_operand_stage_if.slave  bus
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_ZERO  = 2'b11;

    logic              ex_valid_q;
    logic [1:0]        sel_a_q, sel_b_q;
    logic [DATA_W-1:0] rs_q, rt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        sel_a_d, sel_b_d;
    logic              hazard;

    // Producer in ID/EX is checked first: it is younger than the one in EX/MEM.
    function automatic logic [1:0] dec_sel(
        input logic [ADDR_W-1:0] addr,
        input logic              idex_we,
        input logic [ADDR_W-1:0] idex_dst,
        input logic              exmem_we,
        input logic [ADDR_W-1:0] exmem_dst
    );
        if (addr == '0)
            return SEL_ZERO;
        else if (idex_we && (idex_dst == addr))
            return SEL_EXMEM;
        else if (exmem_we && (exmem_dst == addr))
            return SEL_MEMWB;
        else
            return SEL_RF;
    endfunction

    always_comb begin
        sel_a_d = dec_sel(bus.id_rs_addr, bus.idex_wr_en, bus.idex_rd,
                          bus.exmem_wr_en, bus.exmem_rd);
        sel_b_d = dec_sel(bus.id_rt_addr, bus.idex_wr_en, bus.idex_rd,
                          bus.exmem_wr_en, bus.exmem_rd);
        // Conservative: stalls on either address match even if the operand is unused.
        hazard  = bus.id_valid && bus.idex_is_load && bus.idex_wr_en &&
                  (bus.idex_rd != '0) &&
                  ((bus.idex_rd == bus.id_rs_addr) || (bus.idex_rd == bus.id_rt_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            sel_a_q    <= SEL_RF;
            sel_b_q    <= SEL_RF;
            rs_q       <= '0;
            rt_q       <= '0;
        end else if (bus.ex_flush) begin
            ex_valid_q <= 1'b0;
            sel_a_q    <= SEL_RF;
            sel_b_q    <= SEL_RF;
        end else if (bus.ex_hold) begin
            ex_valid_q <= ex_valid_q;
        end else if (hazard) begin
            ex_valid_q <= 1'b0;
            sel_a_q    <= SEL_RF;
            sel_b_q    <= SEL_RF;
        end else begin
            ex_valid_q <= bus.id_valid;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            rs_q       <= bus.id_rs_data;
            rt_q       <= bus.id_rt_data;
        end
    end

    // Counts stall cycles independently of flush; only a downstream hold masks them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (hazard && !bus.ex_hold && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    function automatic logic [DATA_W-1:0] op_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf_val
    );
        case (sel)
            SEL_EXMEM: return bus.exmem_result;
            SEL_MEMWB: return bus.memwb_result;
            SEL_ZERO:  return '0;
            default:   return rf_val;
        endcase
    endfunction

    always_comb begin
        bus.ex_op_a = op_mux(sel_a_q, rs_q);
        bus.ex_op_b = op_mux(sel_b_q, rt_q);
    end

    assign bus.hazard_stall = hazard;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_sel_a     = sel_a_q;
    assign bus.ex_sel_b     = sel_b_q;
    assign bus.stall_count  = cnt_q;

endmodule
